k054539_dac_rx: RTL and testbench

- Receives the 054539 serial audio output (bit clock DTCK, word clock WDCK, front data FRDT, rear data REDT) in the CLK domain.
- Deserialises the stream into parallel signed left/right words for the front and rear pairs.
- Sits directly downstream of the 054539 and replaces the external DAC in simulation and FPGA builds.
- Emits one stereo frame strobe per WDCK period for the mixer/DAC stage.

---
 rtl/k054539_dac_rx.sv | 128 ++++++++++++
 tb/tb_k054539_dac_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/k054539_dac_rx.sv
// k054539_dac_rx: deserialises the 054539 serial audio stream into parallel front/rear stereo words
module k054539_dac_rx #(
    parameter int WORD_BITS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 NRES,
    input  logic                 EN,
    input  logic                 PIN_DTCK,
    input  logic                 PIN_WDCK,
    input  logic                 PIN_FRDT,
    input  logic                 PIN_REDT,
    output logic [WORD_BITS-1:0] FRONT_L,
    output logic [WORD_BITS-1:0] FRONT_R,
    output logic [WORD_BITS-1:0] REAR_L,
    output logic [WORD_BITS-1:0] REAR_R,
    output logic                 FRAME_STB,
    output logic                 SHORT_ERR
);
    localparam int CW = $clog2(WORD_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(WORD_BITS);

    typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] dtck_s, wdck_s, frdt_s, redt_s;
    logic                   dtck_prev, wd_hist, left_ok, upd;
    logic [CW-1:0]          bit_cnt, cnt_nx;
    logic [WORD_BITS-1:0]   front_sr, rear_sr, front_nx, rear_nx, hold_fl, hold_rl;
    logic                   wdck, rise, shift, wd_rise, wd_fall, full;

    // bring the serial pins into the CLK domain
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            dtck_s <= '0;
            wdck_s <= '0;
            frdt_s <= '0;
            redt_s <= '0;
        end else begin
            dtck_s <= {dtck_s[SYNC_STAGES-2:0], PIN_DTCK};
            wdck_s <= {wdck_s[SYNC_STAGES-2:0], PIN_WDCK};
            frdt_s <= {frdt_s[SYNC_STAGES-2:0], PIN_FRDT};
            redt_s <= {redt_s[SYNC_STAGES-2:0], PIN_REDT};
        end
    end

    // bit-clock edge, word-clock edges (seen only on bit-clock rises) and the shifted words including this bit
    always_comb begin
        wdck     = wdck_s[SYNC_STAGES-1];
        rise     = dtck_s[SYNC_STAGES-1] & ~dtck_prev;
        shift    = rise & EN;
        wd_rise  = wdck & ~wd_hist;
        wd_fall  = ~wdck & wd_hist;
        front_nx = {front_sr[WORD_BITS-2:0], frdt_s[SYNC_STAGES-1]};
        rear_nx  = {rear_sr[WORD_BITS-2:0], redt_s[SYNC_STAGES-1]};
        cnt_nx   = (bit_cnt == FULL) ? FULL : bit_cnt + 1'b1;
        full     = cnt_nx == FULL;
    end

    // word framing state machine; output words move together and the strobe follows one CLK later
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            state     <= WAIT_SYNC;
            dtck_prev <= 1'b0;
            wd_hist   <= 1'b0;
            left_ok   <= 1'b0;
            upd       <= 1'b0;
            bit_cnt   <= '0;
            front_sr  <= '0;
            rear_sr   <= '0;
            hold_fl   <= '0;
            hold_rl   <= '0;
            FRONT_L   <= '0;
            FRONT_R   <= '0;
            REAR_L    <= '0;
            REAR_R    <= '0;
            FRAME_STB <= 1'b0;
            SHORT_ERR <= 1'b0;
        end else begin
            dtck_prev <= dtck_s[SYNC_STAGES-1];
            upd       <= 1'b0;
            FRAME_STB <= upd;
            SHORT_ERR <= 1'b0;
            if (rise) wd_hist <= wdck;
            if (!EN) begin
                state   <= WAIT_SYNC;
                bit_cnt <= '0;
                left_ok <= 1'b0;
            end else if (shift) begin
                front_sr <= front_nx;
                rear_sr  <= rear_nx;
                case (state)
                    LEFT: begin
                        bit_cnt <= wd_rise ? '0 : cnt_nx;
                        if (wd_rise) begin
                            state     <= RIGHT;
                            left_ok   <= full;
                            SHORT_ERR <= ~full;
                            if (full) begin
                                hold_fl <= front_nx;
                                hold_rl <= rear_nx;
                            end
                        end
                    end
                    RIGHT: begin
                        bit_cnt <= wd_fall ? '0 : cnt_nx;
                        if (wd_fall) begin
                            state     <= LEFT;
                            SHORT_ERR <= ~full;
                            if (full && left_ok) begin
                                FRONT_L <= hold_fl;
                                REAR_L  <= hold_rl;
                                FRONT_R <= front_nx;
                                REAR_R  <= rear_nx;
                                upd     <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        bit_cnt <= '0;
                        left_ok <= 1'b0;
                        if (wd_fall) state <= LEFT;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_k054539_dac_rx.sv
// tb_k054539_dac_rx: random and directed serial frames checked against a word-level receiver model
module tb_k054539_dac_rx;
    localparam int W = 16;

    logic         clk = 1'b0, nres = 1'b0, en = 1'b0;
    logic         dtck = 1'b0, wdck = 1'b0, frdt = 1'b0, redt = 1'b0;
    logic [W-1:0] front_l, front_r, rear_l, rear_r;
    logic         frame_stb, short_err;

    k054539_dac_rx #(.WORD_BITS(W), .SYNC_STAGES(2)) dut (
        .CLK(clk), .NRES(nres), .EN(en),
        .PIN_DTCK(dtck), .PIN_WDCK(wdck), .PIN_FRDT(frdt), .PIN_REDT(redt),
        .FRONT_L(front_l), .FRONT_R(front_r), .REAR_L(rear_l), .REAR_R(rear_r),
        .FRAME_STB(frame_stb), .SHORT_ERR(short_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, n_stb = 0, n_short = 0;

    typedef struct {
        bit          is_frame;
        logic [63:0] outs;
    } ev_t;
    ev_t expq[$];

    // word-level model: bits gathered between word-clock changes, the last W form the word
    bit           m_synced = 0, m_right = 0, m_prev_wd = 0, m_lok = 0;
    bit           fbits[$], rbits[$];
    logic [W-1:0] m_lf = '0, m_lr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] tail(input bit q[$]);
        logic [W-1:0] v = '0;
        foreach (q[i]) v = {v[W-2:0], q[i]};
        return v;
    endfunction

    task automatic push_ev(input bit is_frame, input logic [63:0] outs);
        ev_t e;
        e.is_frame = is_frame;
        e.outs     = outs;
        expq.push_back(e);
    endtask

    task automatic model_rise(input bit wd, input bit f, input bit r);
        bit ok;
        if (!en) begin
            m_synced = 0;
            fbits.delete();
            rbits.delete();
        end else begin
            fbits.push_back(f);
            rbits.push_back(r);
            if (wd != m_prev_wd) begin
                ok = fbits.size() >= W;
                if (!m_synced) begin
                    if (!wd) begin
                        m_synced = 1;
                        m_right  = 0;
                        m_lok    = 0;
                    end
                end else if (!m_right) begin
                    m_lok = ok;
                    if (ok) begin
                        m_lf = tail(fbits);
                        m_lr = tail(rbits);
                    end else push_ev(0, '0);
                    m_right = 1;
                end else begin
                    if (ok && m_lok) push_ev(1, {m_lf, tail(fbits), m_lr, tail(rbits)});
                    else if (!ok) push_ev(0, '0);
                    m_right = 0;
                end
                fbits.delete();
                rbits.delete();
            end
        end
        m_prev_wd = wd;
    endtask

    task automatic model_reset();
        m_synced  = 0;
        m_right   = 0;
        m_prev_wd = 0;
        m_lok     = 0;
        fbits.delete();
        rbits.delete();
    endtask

    task automatic send_bit(input bit wd, input bit f, input bit r);
        wdck = wd;
        frdt = f;
        redt = r;
        repeat (3) @(negedge clk);
        dtck = 1'b1;
        model_rise(wd, f, r);
        repeat (3) @(negedge clk);
        dtck = 1'b0;
    endtask

    // last bit of a word carries the opposite word-clock level, closing it on that rise
    task automatic send_word(input bit slot, input logic [31:0] f, input logic [31:0] r,
                             input int n, input int drop);
        for (int i = 0; i < n; i++) begin
            if (drop >= 0 && i == drop) en = 1'b0;
            if (drop >= 0 && i == drop + 3) en = 1'b1;
            send_bit((i == n - 1) ? ~slot : slot, f[n-1-i], r[n-1-i]);
        end
        en = 1'b1;
    endtask

    task automatic send_pair(input logic [15:0] fl, input logic [15:0] rl,
                             input logic [15:0] fr, input logic [15:0] rr);
        send_word(0, {16'h0, fl}, {16'h0, rl}, W, -1);
        send_word(1, {16'h0, fr}, {16'h0, rr}, W, -1);
        repeat (6) @(negedge clk);
    endtask

    // per-cycle compare against the model's event queue and the output-update-then-strobe rule
    logic [63:0] prev_outs = '0;
    bit          pend = 0;
    always @(negedge clk) begin
        logic [63:0] outs;
        ev_t         e;
        outs = {front_l, front_r, rear_l, rear_r};
        if (!nres) begin
            check("reset_state", {outs, frame_stb, short_err}, '0);
            prev_outs = '0;
            pend      = 0;
        end else begin
            check("stb_err_exclusive", {63'h0, frame_stb & short_err}, '0);
            if (pend) check("stb_after_update", {63'h0, frame_stb}, 64'h1);
            if (frame_stb) begin
                n_stb++;
                if (expq.size() == 0) check("frame_expected", 64'h0, 64'h1);
                else begin
                    e = expq.pop_front();
                    check("frame_kind", {63'h0, e.is_frame}, 64'h1);
                    check("frame_data", outs, e.outs);
                end
            end
            if (short_err) begin
                n_short++;
                if (expq.size() == 0) check("short_expected", 64'h0, 64'h1);
                else begin
                    e = expq.pop_front();
                    check("short_kind", {63'h0, e.is_frame}, 64'h0);
                end
            end
            pend      = outs != prev_outs;
            prev_outs = outs;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        repeat (3) @(negedge clk);
        nres = 1'b1;
        en   = 1'b1;
        repeat (2) @(negedge clk);
        // nominal frame after a word-clock fall
        send_word(1, 0, 0, 4, -1);
        send_pair(16'h1234, 16'h8001, 16'hABCD, 16'h7FFF);
        check("nom_front_l", {48'h0, front_l}, 64'h1234);
        check("nom_rear_l", {48'h0, rear_l}, 64'h8001);
        check("nom_front_r", {48'h0, front_r}, 64'hABCD);
        check("nom_rear_r", {48'h0, rear_r}, 64'h7FFF);
        check("nom_stb_count", n_stb, 1);
        // long left word keeps the last 16 bits
        send_word(0, 32'h300FF, 32'h0, 18, -1);
        send_word(1, 32'h4321, 32'h0, W, -1);
        repeat (6) @(negedge clk);
        check("long_front_l", {48'h0, front_l}, 64'h00FF);
        check("long_front_r", {48'h0, front_r}, 64'h4321);
        check("long_no_short", n_short, 0);
        // short right word
        send_word(0, 32'h1111, 32'h1111, W, -1);
        send_word(1, 32'h2222, 32'h2222, 12, -1);
        repeat (6) @(negedge clk);
        check("short_count", n_short, 1);
        check("short_no_stb", n_stb, 2);
        check("short_hold_l", {48'h0, front_l}, 64'h00FF);
        check("short_hold_r", {48'h0, front_r}, 64'h4321);
        // enable dropped inside a left word
        send_word(0, 32'h3333, 32'h3333, W, 5);
        send_word(1, 32'h4444, 32'h4444, W, -1);
        repeat (6) @(negedge clk);
        check("en_no_stb", n_stb, 2);
        send_pair(16'h5555, 16'h5A5A, 16'h6666, 16'hA5A5);
        check("en_resume_stb", n_stb, 3);
        check("en_resume_l", {48'h0, front_l}, 64'h5555);
        // back-to-back frames
        for (int k = 1; k <= 4; k++) send_pair(16'(k), 16'(k * 3), 16'(k), 16'(k * 5));
        check("b2b_stb", n_stb, 7);
        check("b2b_front", {32'h0, front_l, front_r}, 64'h0004_0004);
        // random words, lengths and enable drops
        for (int k = 0; k < 40; k++) begin
            int n, d;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 20) : W;
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            send_word(k[0], $urandom, $urandom, n, d);
        end
        repeat (6) @(negedge clk);
        send_pair(16'hBEEF, 16'h0F0F, 16'hCAFE, 16'hF0F0);
        send_pair(16'hBEEF, 16'h0F0F, 16'hCAFE, 16'hF0F0);
        check("post_rand_l", {48'h0, front_l}, 64'hBEEF);
        // reset asserted mid-word
        for (int i = 0; i < 7; i++) send_bit(0, 1, 1);
        #3 nres = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_outputs", {front_l, front_r, rear_l, rear_r}, 64'h0);
        nres = 1'b1;
        s0   = n_stb;
        send_pair(16'h7777, 16'h7777, 16'h8888, 16'h8888);
        check("rst_wait_sync", n_stb, s0);
        send_pair(16'h1357, 16'h9BDF, 16'h2468, 16'hACE0);
        check("rst_first_frame", n_stb, s0 + 1);
        check("rst_frame_data", {front_l, front_r, rear_l, rear_r}, 64'h1357_2468_9BDF_ACE0);
        repeat (20) @(negedge clk);
        check("events_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
